// File: rtl/matrix_nxn_buff_pkg.sv
// matrix_pkg: shared types, default dimensions and width helpers for the
// matrix_nxn_buff input stage (MAT_N x MAT_N matrices of Q2.10 elements).
package matrix_pkg;

    localparam int MAT_N = 4;
    localparam int MAT_W = 12;

    typedef logic [MAT_W-1:0] fxp_t;
    typedef fxp_t [MAT_N-1:0][MAT_N-1:0] mat_t;

    // Width of a row/col index; a dimension of 1 still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an element counter that must hold the value n*n.
    function automatic int cnt_w(input int n);
        return $clog2(n * n + 1);
    endfunction

endpackage

// File: rtl/matrix_nxn_buff_bank.sv
// matrix_nxn_bank: one N x N storage bank for the A and B operands.
// Single write port addressed by (col, row); both matrices are read out in
// full every cycle. Contents reset to zero; a synchronous abort upstream
// never touches this storage.
module matrix_nxn_bank
    import matrix_pkg::*;
#(
    parameter int N = MAT_N,
    parameter int W = MAT_W
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         we_i,
    input  logic [idx_w(N)-1:0]          col_i,
    input  logic [idx_w(N)-1:0]          row_i,
    input  logic [W-1:0]                 a_i,
    input  logic [W-1:0]                 b_i,
    output logic [N-1:0][N-1:0][W-1:0]   a_mat_o,
    output logic [N-1:0][N-1:0][W-1:0]   b_mat_o
);

    logic [N-1:0][N-1:0][W-1:0] a_q;
    logic [N-1:0][N-1:0][W-1:0] b_q;

    // Element storage: write the addressed A/B pair when enabled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q <= '0;
            b_q <= '0;
        end else if (we_i) begin
            a_q[col_i][row_i] <= a_i;
            b_q[col_i][row_i] <= b_i;
        end
    end

    assign a_mat_o = a_q;
    assign b_mat_o = b_q;

endmodule

// File: rtl/matrix_nxn_buff.sv
// matrix_nxn_buff: collects two N x N matrices (A, B) one element pair per
// input handshake in column-major order (row increments first), then
// presents both complete matrices to the multiplier array.
// Optional feature macro: MATRIX_BUFF_PINGPONG_EN selects two banks so the
// next operand pair can fill while the current one is presented; without
// it a single bank is used and filling waits for the output transfer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid_out and ready_out are decoded purely from registered
// occupancy, so neither depends combinationally on any input. clear is a
// synchronous abort that wins over both handshakes in the same cycle.
module matrix_nxn_buff
    import matrix_pkg::*;
#(
    parameter int N = MAT_N,
    parameter int W = MAT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic [W-1:0]                 a_in,
    input  logic [W-1:0]                 b_in,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [N-1:0][N-1:0][W-1:0]   a_mat,
    output logic [N-1:0][N-1:0][W-1:0]   b_mat,
    output logic [cnt_w(N)-1:0]          fill_cnt
);

    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    occ_q, occ_d;

    logic in_fire;
    logic out_fire;
    logic fill_done;
    logic wr_en;

    logic [N-1:0][N-1:0][W-1:0] bank0_a, bank0_b;

    assign in_fire   = valid_in && ready_out;
    assign out_fire  = valid_out && ready_in;
    assign fill_done = in_fire && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign wr_en     = in_fire && !clear;

    assign valid_out = (occ_q != 2'd0);
    assign fill_cnt  = cnt_q;

    // Fill counters and occupancy: advance on accepted input, release on
    // accepted output, everything back to zero on abort.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        occ_d = occ_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
            occ_d = 2'd0;
        end else begin
            if (in_fire) begin
                if (row_q == LAST_IDX) begin
                    row_d = '0;
                    col_d = (col_q == LAST_IDX) ? '0 : col_q + IW'(1);
                end else begin
                    row_d = row_q + IW'(1);
                end
                cnt_d = fill_done ? '0 : cnt_q + CW'(1);
            end
            occ_d = occ_q + {1'b0, fill_done} - {1'b0, out_fire};
        end
    end

    // Counter and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
            occ_q <= 2'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
            occ_q <= occ_d;
        end
    end

`ifdef MATRIX_BUFF_PINGPONG_EN
    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;
    logic [N-1:0][N-1:0][W-1:0] bank1_a, bank1_b;

    // Bank pointers: the fill side flips on completion, the read side on
    // release; both may flip on the same edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (fill_done) wr_ptr_d = ~wr_ptr_q;
            if (out_fire)  rd_ptr_d = ~rd_ptr_q;
        end
    end

    // Bank pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    matrix_nxn_bank #(.N(N), .W(W)) u_bank0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (wr_en && !wr_ptr_q),
        .col_i   (col_q),
        .row_i   (row_q),
        .a_i     (a_in),
        .b_i     (b_in),
        .a_mat_o (bank0_a),
        .b_mat_o (bank0_b)
    );

    matrix_nxn_bank #(.N(N), .W(W)) u_bank1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (wr_en && wr_ptr_q),
        .col_i   (col_q),
        .row_i   (row_q),
        .a_i     (a_in),
        .b_i     (b_in),
        .a_mat_o (bank1_a),
        .b_mat_o (bank1_b)
    );

    assign a_mat     = rd_ptr_q ? bank1_a : bank0_a;
    assign b_mat     = rd_ptr_q ? bank1_b : bank0_b;
    assign ready_out = (occ_q != 2'd2);
`else
    // Single bank: both pointers are implicitly zero.
    matrix_nxn_bank #(.N(N), .W(W)) u_bank0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (wr_en),
        .col_i   (col_q),
        .row_i   (row_q),
        .a_i     (a_in),
        .b_i     (b_in),
        .a_mat_o (bank0_a),
        .b_mat_o (bank0_b)
    );

    assign a_mat     = bank0_a;
    assign b_mat     = bank0_b;
    assign ready_out = (occ_q == 2'd0);
`endif

endmodule

// File: tb/tb_matrix_nxn_buff.sv
// Bench for matrix_nxn_buff: main N=4 instance plus N=2 and N=8 instances.
// Inputs change 1 time unit after the rising edge; outputs are checked
// there too, or on the falling edge by the output monitor.
module tb_matrix_nxn_buff;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int CW = $clog2(N * N + 1);

    // ---------------- clock / reset / signals ----------------
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic clear    = 1'b0;
    logic valid_in = 1'b0;
    logic ready_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic ready_out, valid_out;
    logic [N-1:0][N-1:0][W-1:0] a_mat, b_mat;
    logic [CW-1:0] fill_cnt;

    logic v2 = 1'b0;
    logic [W-1:0] a2 = '0, b2 = '0;
    logic ro2, vo2;
    logic [1:0][1:0][W-1:0] am2, bm2;
    logic [2:0] fc2;

    logic v8 = 1'b0;
    logic [W-1:0] a8 = '0, b8 = '0;
    logic ro8, vo8;
    logic [7:0][7:0][W-1:0] am8, bm8;
    logic [6:0] fc8;

    always #5 clk = ~clk;

    matrix_nxn_buff #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .ready_out(ready_out), .a_in(a_in), .b_in(b_in), .valid_out(valid_out),
        .ready_in(ready_in), .a_mat(a_mat), .b_mat(b_mat), .fill_cnt(fill_cnt)
    );

    matrix_nxn_buff #(.N(2), .W(W)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .valid_in(v2),
        .ready_out(ro2), .a_in(a2), .b_in(b2), .valid_out(vo2),
        .ready_in(1'b0), .a_mat(am2), .b_mat(bm2), .fill_cnt(fc2)
    );

    matrix_nxn_buff #(.N(8), .W(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .valid_in(v8),
        .ready_out(ro8), .a_in(a8), .b_in(b8), .valid_out(vo8),
        .ready_in(1'b0), .a_mat(am8), .b_mat(bm8), .fill_cnt(fc8)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    bit mon_en = 1'b0;
    int out_seen = 0;
    logic [W-1:0] mon_base;
    bit mon_ok;

    // Output transfer monitor: each release must carry the next queued matrix
    // (a = base + idx, b = base + 0x800 + idx, idx = col*N + row).
    always @(negedge clk) begin
        if (mon_en && valid_out && ready_in) begin
            total++;
            out_seen++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got an output transfer, want none");
            end else begin
                mon_base = exp_q.pop_front();
                mon_ok = 1'b1;
                for (int c = 0; c < N; c++)
                    for (int r = 0; r < N; r++)
                        if (a_mat[c][r] !== mon_base + W'(c * N + r) ||
                            b_mat[c][r] !== mon_base + 12'h800 + W'(c * N + r))
                            mon_ok = 1'b0;
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL out_matrix: got a00=%h b00=%h want a00=%h b00=%h",
                             a_mat[0][0], b_mat[0][0], mon_base, mon_base + 12'h800);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int cycles);
        bit rdy;
        cycles = 0;
        valid_in = 1'b1;
        a_in = a;
        b_in = b;
        for (int t = 0; t < 100; t++) begin
            rdy = ready_out;
            @(posedge clk); #1;
            cycles++;
            if (rdy) begin
                valid_in = 1'b0;
                return;
            end
        end
        valid_in = 1'b0;
        total++;
        bad++;
        $display("FAIL send_timeout: got ready_out=0 for 100 cycles, want 1");
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit zero;
        #12;
        total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || fill_cnt !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
                     valid_out, ready_out, fill_cnt);
        end
        zero = (a_mat == '0) && (b_mat == '0);
        total++;
        if (!zero) begin
            bad++;
            $display("FAIL reset_mat: got a00=%h want 000", a_mat[0][0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_fill();
        int cyc;
        ready_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(12'h001 + W'(i), 12'h100 + W'(i), cyc);
            if (i == 8) begin
                total++;
                if (fill_cnt !== CW'(9)) begin
                    bad++;
                    $display("FAIL fill_cnt9: got %0d want 9", fill_cnt);
                end
            end
            if (i == 14) begin
                total++;
                if (valid_out !== 1'b0) begin
                    bad++;
                    $display("FAIL early_valid: got %b want 0", valid_out);
                end
            end
        end
        total++;
        if (valid_out !== 1'b1 || fill_cnt !== '0) begin
            bad++;
            $display("FAIL fill_valid: got v=%b cnt=%0d want v=1 cnt=0", valid_out, fill_cnt);
        end
        total++;
        if (a_mat[1][2] !== 12'h007 || b_mat[3][3] !== 12'h10F) begin
            bad++;
            $display("FAIL fill_data: got a12=%h b33=%h want 007 10f", a_mat[1][2], b_mat[3][3]);
        end
        total++;
`ifdef MATRIX_BUFF_PINGPONG_EN
        if (ready_out !== 1'b1) begin
            bad++;
            $display("FAIL full_ready: got %b want 1", ready_out);
        end
`else
        if (ready_out !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got %b want 0", ready_out);
        end
`endif
    endtask

    task automatic test_release();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL release: got v=%b r=%b want v=0 r=1", valid_out, ready_out);
        end
    endtask

    task automatic test_gaps_backpressure();
        int cyc;
        bit ok;
        ready_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
            send(12'h001 + W'(i), 12'h100 + W'(i), cyc);
        end
`ifndef MATRIX_BUFF_PINGPONG_EN
        valid_in = 1'b1;
        a_in = 12'hBAD;
        b_in = 12'hBAD;
`endif
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int c = 0; c < N; c++)
                for (int r = 0; r < N; r++)
                    if (a_mat[c][r] !== 12'h001 + W'(c * N + r) ||
                        b_mat[c][r] !== 12'h100 + W'(c * N + r))
                        ok = 1'b0;
            total++;
            if (!ok || valid_out !== 1'b1) begin
                bad++;
                $display("FAIL hold_data: cycle %0d got v=%b a00=%h want v=1 a00=001",
                         k, valid_out, a_mat[0][0]);
            end
`ifndef MATRIX_BUFF_PINGPONG_EN
            total++;
            if (ready_out !== 1'b0 || fill_cnt !== '0) begin
                bad++;
                $display("FAIL backpressure: got r=%b cnt=%0d want r=0 cnt=0", ready_out, fill_cnt);
            end
`endif
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        test_release();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int sum;
        int want_cyc;
        logic [W-1:0] base;
        sum = 0;
        out_seen = 0;
        mon_en = 1'b1;
        ready_in = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            base = W'(m * 64);
            exp_q.push_back(base);
            for (int i = 0; i < 16; i++) begin
                send(base + W'(i), base + 12'h800 + W'(i), cyc);
                sum += cyc;
            end
        end
`ifdef MATRIX_BUFF_PINGPONG_EN
        want_cyc = 48;
`else
        want_cyc = 50;
`endif
        total++;
        if (sum != want_cyc) begin
            bad++;
            $display("FAIL b2b_cycles: got %0d want %0d", sum, want_cyc);
        end
        for (int t = 0; t < 10 && valid_out; t++) begin
            @(posedge clk); #1;
        end
        total++;
        if (out_seen != 3 || exp_q.size() != 0 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_outputs: got %0d transfers v=%b want 3 v=0", out_seen, valid_out);
        end
        mon_en = 1'b0;
        ready_in = 1'b0;
    endtask

    task automatic test_clear_mid_fill();
        int cyc;
        bit ok;
        ready_in = 1'b0;
        for (int i = 0; i < 9; i++) send(12'hFFF - W'(i), 12'hEEE, cyc);
        total++;
        if (fill_cnt !== CW'(9)) begin
            bad++;
            $display("FAIL clear_pre: got %0d want 9", fill_cnt);
        end
        clear = 1'b1;
        valid_in = 1'b1;
        a_in = 12'hDDD;
        b_in = 12'hDDD;
        @(posedge clk); #1;
        clear = 1'b0;
        valid_in = 1'b0;
        total++;
        if (fill_cnt !== '0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL clear_post: got cnt=%0d v=%b r=%b want cnt=0 v=0 r=1",
                     fill_cnt, valid_out, ready_out);
        end
        for (int i = 0; i < 16; i++) send(12'h200 + W'(i), 12'hA00 + W'(i), cyc);
        ok = 1'b1;
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++)
                if (a_mat[c][r] !== 12'h200 + W'(c * N + r) ||
                    b_mat[c][r] !== 12'hA00 + W'(c * N + r))
                    ok = 1'b0;
        total++;
        if (!ok || valid_out !== 1'b1) begin
            bad++;
            $display("FAIL clear_fresh: got v=%b a00=%h a33=%h want v=1 a00=200 a33=20f",
                     valid_out, a_mat[0][0], a_mat[3][3]);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || fill_cnt !== '0) begin
            bad++;
            $display("FAIL areset_ctrl: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
                     valid_out, ready_out, fill_cnt);
        end
        total++;
        if (a_mat != '0 || b_mat != '0) begin
            bad++;
            $display("FAIL areset_mat: got a00=%h b00=%h want 000 000", a_mat[0][0], b_mat[0][0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL areset_after: got v=%b want 0", valid_out);
        end
    endtask

    task automatic test_n2();
        for (int i = 0; i < 4; i++) begin
            v2 = 1'b1;
            a2 = W'(i + 1);
            b2 = 12'h300 + W'(i);
            @(posedge clk); #1;
            if (i == 1) begin
                total++;
                if (fc2 !== 3'd2) begin
                    bad++;
                    $display("FAIL n2_cnt: got %0d want 2", fc2);
                end
            end
            if (i == 2) begin
                total++;
                if (vo2 !== 1'b0) begin
                    bad++;
                    $display("FAIL n2_early: got %b want 0", vo2);
                end
            end
        end
        v2 = 1'b0;
        total++;
        if (vo2 !== 1'b1 || ro2 !== 1'b0 && 0) begin
            bad++;
            $display("FAIL n2_valid: got %b want 1", vo2);
        end
        total++;
        if (am2[0][1] !== 12'h002 || am2[1][0] !== 12'h003 || bm2[1][1] !== 12'h303) begin
            bad++;
            $display("FAIL n2_data: got a01=%h a10=%h b11=%h want 002 003 303",
                     am2[0][1], am2[1][0], bm2[1][1]);
        end
    endtask

    task automatic test_n8();
        for (int i = 0; i < 64; i++) begin
            v8 = 1'b1;
            a8 = W'(i + 1);
            b8 = 12'h500 + W'(i);
            @(posedge clk); #1;
            if (i == 62) begin
                total++;
                if (vo8 !== 1'b0 || fc8 !== 7'd63) begin
                    bad++;
                    $display("FAIL n8_early: got v=%b cnt=%0d want v=0 cnt=63", vo8, fc8);
                end
            end
        end
        v8 = 1'b0;
        total++;
        if (vo8 !== 1'b1 || fc8 !== 7'd0) begin
            bad++;
            $display("FAIL n8_valid: got v=%b cnt=%0d want v=1 cnt=0", vo8, fc8);
        end
        total++;
        if (am8[0][7] !== 12'h008 || am8[1][0] !== 12'h009 || am8[7][7] !== 12'h040 ||
            bm8[7][7] !== 12'h53F) begin
            bad++;
            $display("FAIL n8_data: got a07=%h a10=%h a77=%h b77=%h want 008 009 040 53f",
                     am8[0][7], am8[1][0], am8[7][7], bm8[7][7]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_fill();
        test_release();
        test_gaps_backpressure();
        test_back_to_back();
        test_clear_mid_fill();
        test_async_reset();
        test_n2();
        test_n8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time 200000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
